// File: rtl/muldiv_seq_r0_pkg.sv
// Shared op/state codes and default widths for the iterative HI/LO multiply/divide unit.
// Op decode helpers live here so the FSM and the start path agree on one encoding.
package muldiv_seq_r0_pkg;

  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_r0_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
// The EX side drives the master modport; the sequencer owns the slave modport.
interface muldiv_seq_r0_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    en_n;
  logic [2*DATA_WIDTH-1:0] dataIn;
  logic                    start;
  logic [1:0]              op;
  logic                    mthi;
  logic                    mtlo;
  logic                    rd_hi;
  logic                    rd_lo;
  logic [DATA_WIDTH-1:0]   dataOut;
  logic [DATA_WIDTH-1:0]   hi;
  logic [DATA_WIDTH-1:0]   lo;
  logic                    busy;
  logic                    done;
  logic                    div_zero;
  logic                    stall;

  modport master (
    output en_n, dataIn, start, op, mthi, mtlo, rd_hi, rd_lo,
    input  dataOut, hi, lo, busy, done, div_zero, stall
  );

  modport slave (
    input  en_n, dataIn, start, op, mthi, mtlo, rd_hi, rd_lo,
    output dataOut, hi, lo, busy, done, div_zero, stall
  );
endinterface

// File: rtl/muldiv_step_r0.sv
// One radix-2 iteration: right-shift shift-add multiply or left-shift restoring divide.
// Purely combinational; accumulator is {carry/remainder top bit, upper W, lower W}.
module muldiv_step_r0 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    is_div,
  input  logic [2*DATA_WIDTH:0]   acc_i,
  input  logic [DATA_WIDTH-1:0]   opnd_i,
  output logic [2*DATA_WIDTH:0]   acc_o
);
  localparam int W = DATA_WIDTH;

  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] diff;

  always_comb begin
    sum    = acc_i[2*W:W] + (acc_i[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
    // Remainder shifted left with the next dividend bit brought in.
    rem_sh = acc_i[2*W-1:W-1];
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div) begin
      if (rem_sh >= {1'b0, opnd_i}) begin
        acc_o = {diff, acc_i[W-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh, acc_i[W-2:0], 1'b0};
      end
    end else begin
      acc_o = {1'b0, sum, acc_i[W-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq_r0.sv
// HI/LO owner: MULT/MULTU/DIV/DIVU over W+1 busy cycles (magnitudes, W steps, sign fix).
// While busy, any HI/LO request raises stall and is dropped; the requester re-presents it.
module muldiv_seq_r0
  import muldiv_seq_r0_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH,
  parameter int CNT_WIDTH  = MD_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  muldiv_seq_r0_if.slave   bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(W - 1);

  md_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [2*W:0]         acc_q, acc_d, acc_step;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic [W-1:0]   rs, rt, rs_mag, rt_mag;
  logic           rs_neg, rt_neg, op_div;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix, rem_fix;

  assign rs     = bus.dataIn[2*W-1:W];
  assign rt     = bus.dataIn[W-1:0];
  assign op_div = md_is_div(bus.op);
  assign rs_neg = md_is_signed(bus.op) & rs[W-1];
  assign rt_neg = md_is_signed(bus.op) & rt[W-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  // neg_q: product/quotient sign; rneg_q: remainder follows the dividend.
  assign prod_fix = neg_q  ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
  assign quot_fix = neg_q  ? -acc_q[W-1:0]   : acc_q[W-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  muldiv_step_r0 #(.DATA_WIDTH(W)) u_step (
    .is_div (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_d      = div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      MD_IDLE: begin
        if (bus.start) begin
          div_d   = op_div;
          opnd_d  = op_div ? rt_mag : rs_mag;
          acc_d   = {{(W+1){1'b0}}, (op_div ? rs_mag : rt_mag)};
          neg_d   = rs_neg ^ rt_neg;
          rneg_d  = rs_neg;
          dz_d    = (rt == '0);
          count_d = '0;
          state_d = MD_CALC;
        end else begin
          if (bus.mthi) hi_d = rs;
          if (bus.mtlo) lo_d = rs;
        end
      end
      MD_CALC: begin
        acc_d = acc_step;
        if (count_q == LAST_CNT) begin
          state_d = MD_FIX;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      MD_FIX: begin
        if (div_q) begin
          // Divide-by-zero leaves the dividend as remainder; quotient is forced to all ones.
          lo_d = dz_q ? {W{1'b1}} : quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        div_zero_d = div_q & dz_q;
        done_d     = 1'b1;
        state_d    = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (!bus.en_n) begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_q      <= div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != MD_IDLE);
  assign bus.stall    = bus.busy & (bus.start | bus.mthi | bus.mtlo | bus.rd_hi | bus.rd_lo);
  assign bus.dataOut  = bus.rd_hi ? hi_q : lo_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
endmodule
